// File: rtl/lsrb_decider.sv
// LSRB line-follower decider: debounces the IR sensor array, probes junctions and
// emits a one-hot move word. Optional decision log enabled by defining PATH_LOG_EN.
module lsrb_decider #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int PROBE_CYC    = 8,
  parameter int TURN_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [0:4] line_sns,
  input  logic       turn_done,
  output logic [0:3] lsrb,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] junction_cnt,
  output logic [4:0] path_len,
  input  logic [3:0] path_rd_addr,
  output logic [1:0] path_rd_data
);

  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int PW = $clog2(PROBE_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FOLLOW, S_PROBE, S_DECIDE, S_TURN, S_DONE, S_FAULT
  } state_e;

  typedef enum logic [1:0] {MOVE_L = 2'd0, MOVE_S = 2'd1, MOVE_R = 2'd2, MOVE_B = 2'd3} move_e;

  function automatic logic [0:3] onehot(input move_e m);
    return 4'(4'b1000 >> m);
  endfunction

  state_e          state_q, state_d;
  move_e           move_q, move_d;
  logic [0:4]      raw_q, raw_d, deb_q, deb_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [7:0]      timer_q, timer_d;
  logic [7:0]      jcnt_q, jcnt_d;
  logic            lseen_q, lseen_d, rseen_q, rseen_d, sav_q, sav_d;
  logic [0:3]      lsrb_q, lsrb_d;
  logic            busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic            log_we, log_clr;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    raw_d   = line_sns;
    dcnt_d  = dcnt_q;
    deb_d   = deb_q;
    state_d = state_q;
    move_d  = move_q;
    pcnt_d  = pcnt_q;
    timer_d = timer_q;
    jcnt_d  = jcnt_q;
    lseen_d = lseen_q;
    rseen_d = rseen_q;
    sav_d   = sav_q;
    log_we  = 1'b0;
    log_clr = 1'b0;

    // Debounce: a run of DEBOUNCE_CYC identical samples commits the pattern.
    if (line_sns != raw_q)                   dcnt_d = '0;
    else if (dcnt_q != DW'(DEBOUNCE_CYC - 1)) dcnt_d = dcnt_q + 1'b1;
    if (dcnt_d == DW'(DEBOUNCE_CYC - 1))      deb_d  = line_sns;

    case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          state_d = S_FOLLOW;
          jcnt_d  = '0;
          log_clr = 1'b1;
        end
      end
      S_FOLLOW: begin
        if (deb_q[0] || deb_q[4]) begin
          state_d = S_PROBE;
          lseen_d = deb_q[0];
          rseen_d = deb_q[4];
          pcnt_d  = '0;
        end else if (deb_q == 5'b00000) begin
          state_d = S_DECIDE;
          lseen_d = 1'b0;
          rseen_d = 1'b0;
          sav_d   = 1'b0;
        end
      end
      S_PROBE: begin
        lseen_d = lseen_q | deb_q[0];
        rseen_d = rseen_q | deb_q[4];
        if (pcnt_q == PW'(PROBE_CYC - 1)) begin
          if (deb_q == 5'b11111) begin
            state_d = S_DONE;
          end else begin
            sav_d   = deb_q[2];
            state_d = S_DECIDE;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_DECIDE: begin
        move_d = lseen_q ? MOVE_L : sav_q ? MOVE_S : rseen_q ? MOVE_R : MOVE_B;
        log_we = 1'b1;
        if (jcnt_q != 8'hFF) jcnt_d = jcnt_q + 8'd1;
        if (move_d == MOVE_S) begin
          state_d = S_FOLLOW;
        end else begin
          state_d = S_TURN;
          timer_d = '0;
        end
      end
      S_TURN: begin
        // turn_done on the timeout cycle still counts as a completed turn.
        if (turn_done)                              state_d = S_FOLLOW;
        else if (timer_q == 8'(TURN_TIMEOUT - 1))   state_d = S_FAULT;
        else                                        timer_d = timer_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    lsrb_d  = 4'b0000;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      S_FOLLOW, S_PROBE, S_DECIDE: begin lsrb_d = onehot(MOVE_S); busy_d = 1'b1; end
      S_TURN:                      begin lsrb_d = onehot(move_d); busy_d = 1'b1; end
      S_DONE:                      done_d  = 1'b1;
      S_FAULT:                     fault_d = 1'b1;
      default:                     ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      move_q  <= MOVE_S;
      raw_q   <= '0;
      deb_q   <= '0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      timer_q <= '0;
      jcnt_q  <= '0;
      lseen_q <= 1'b0;
      rseen_q <= 1'b0;
      sav_q   <= 1'b0;
      lsrb_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      move_q  <= move_d;
      raw_q   <= raw_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      timer_q <= timer_d;
      jcnt_q  <= jcnt_d;
      lseen_q <= lseen_d;
      rseen_q <= rseen_d;
      sav_q   <= sav_d;
      lsrb_q  <= lsrb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign lsrb         = lsrb_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault        = fault_q;
  assign junction_cnt = jcnt_q;

`ifdef PATH_LOG_EN
  logic [4:0] plen_q, plen_d;
  logic [1:0] log_q [16];
  logic [1:0] log_d [16];

  always_comb begin
    plen_d = plen_q;
    log_d  = log_q;
    if (log_clr) begin
      plen_d = '0;
      for (int i = 0; i < 16; i++) log_d[i] = '0;
    end else if (log_we && plen_q < 5'd16) begin
      log_d[plen_q[3:0]] = move_d;
      plen_d             = plen_q + 5'd1;
    end
  end

  // NOTE: the log is small and must read as cleared after reset, so it is reset
  // explicitly rather than left as uninitialised storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plen_q <= '0;
      for (int i = 0; i < 16; i++) log_q[i] <= '0;
    end else begin
      plen_q <= plen_d;
      log_q  <= log_d;
    end
  end

  assign path_len     = plen_q;
  assign path_rd_data = log_q[path_rd_addr];
`else
  logic unused_log;
  assign unused_log   = ^{path_rd_addr, log_we, log_clr};
  assign path_len     = '0;
  assign path_rd_data = '0;
`endif

endmodule
